// File: rtl/dmem_bridge_if.sv
// Data-bus side of the memory bridge: registered request and write
// data toward the memory, with ready/read data coming back.
interface dmem_bridge_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/dmem_bridge.sv
// Bridges the single-cycle datapath's data-memory port onto a
// variable-latency req/ready bus, stalling the datapath until the
// access completes and flagging misaligned accesses and timeouts.
module dmem_bridge #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign,
  output logic        timeout_err,
  dmem_bridge_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DONE
  } state_t;

  localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic        terr_q, terr_d;
  logic        misalign_q, misalign_d;
  logic        stall_c;
  logic        access;
  logic        aligned;

  assign access  = memread | memwrite;
  assign aligned = (addr[1:0] == 2'b00);

  // Next-state, bus register updates and combinational stall
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    terr_d     = terr_q;
    misalign_d = 1'b0;
    stall_c    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        rdata_d = '0;
        if (access) begin
          if (aligned) begin
            stall_c = 1'b1;
            addr_d  = {addr[31:2], 2'b00};
            wdata_d = wdata;
            we_d    = memwrite;
            req_d   = 1'b1;
            cnt_d   = '0;
            state_d = ST_REQ;
          end else begin
            misalign_d = 1'b1;
          end
        end
      end
      ST_REQ: begin
        stall_c = 1'b1;
        // ready takes priority over an expiring timeout in the same cycle
        if (bus.bus_ready) begin
          req_d   = 1'b0;
          rdata_d = we_q ? '0 : bus.bus_rdata;
          state_d = ST_DONE;
        end else if (cnt_q == TIMEOUT_M1) begin
          req_d   = 1'b0;
          terr_d  = 1'b1;
          rdata_d = we_q ? '0 : ERR_DATA;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DONE: begin
        // rdata holds through DONE and clears on the way back to IDLE
        rdata_d = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and bus registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
      terr_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      terr_q     <= terr_d;
      misalign_q <= misalign_d;
    end
  end

  // stall is gated by reset so an access presented during reset cannot freeze the PC
  assign stall         = stall_c & reset;
  assign rdata         = rdata_q;
  assign misalign      = misalign_q;
  assign timeout_err   = terr_q;
  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: directed scenarios plus random
// accesses checked against a transaction-level model of the bridge.
module tb_dmem_bridge;

  localparam int unsigned TIMEOUT_P = 4;
  localparam logic [31:0] ERR_P     = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memread = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        stall;
  logic        misalign;
  logic        timeout_err;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic        exp_terr = 1'b0;

  dmem_bridge_if bus_if ();

  dmem_bridge #(.TIMEOUT(TIMEOUT_P), .ERR_DATA(ERR_P)) dut (
    .clk         (clk),
    .reset       (reset),
    .memread     (memread),
    .memwrite    (memwrite),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .stall       (stall),
    .misalign    (misalign),
    .timeout_err (timeout_err),
    .bus         (bus_if.master)
  );

  always #5 clk = ~clk;

  initial begin
    bus_if.bus_ready = 1'b0;
    bus_if.bus_rdata = '0;
  end

  // One aligned access, driven from the first IDLE cycle to the cycle after DONE.
  // Expected behaviour comes from the transaction rules: the access stays on
  // the bus until the cycle bus_ready arrives or TIMEOUT request cycles pass.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input int unsigned waits,
                            input logic [31:0] rv, input string name);
    bit          to        = (waits >= TIMEOUT_P);
    int unsigned req_cyc   = to ? TIMEOUT_P : waits + 1;
    logic        exp_we    = wr;
    logic [31:0] exp_rdata = wr ? 32'h0 : (to ? ERR_P : rv);
    int unsigned stall_cnt = 0;
    int unsigned req_cnt   = 0;
    memread          = rd;
    memwrite         = wr;
    addr             = a;
    wdata            = wd;
    bus_if.bus_ready = 1'($urandom);
    @(negedge clk);
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL %s idle_stall got=%b exp=1", name, stall); end
    n_cmp++; if (bus_if.bus_req !== 1'b0) begin n_err++; $display("FAIL %s idle_req got=%b exp=0", name, bus_if.bus_req); end
    n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL %s idle_rdata got=%h exp=0", name, rdata); end
    if (stall === 1'b1) stall_cnt++;
    @(posedge clk); #1;
    for (int unsigned k = 0; k < req_cyc; k++) begin
      addr             = $urandom;
      wdata            = $urandom;
      bus_if.bus_ready = (!to && k == waits);
      bus_if.bus_rdata = (k == waits) ? rv : $urandom;
      @(negedge clk);
      n_cmp++; if (bus_if.bus_req !== 1'b1) begin n_err++; $display("FAIL %s req_%0d got=%b exp=1", name, k, bus_if.bus_req); end
      n_cmp++; if (bus_if.bus_we !== exp_we) begin n_err++; $display("FAIL %s we_%0d got=%b exp=%b", name, k, bus_if.bus_we, exp_we); end
      n_cmp++; if (bus_if.bus_addr !== {a[31:2], 2'b00}) begin n_err++; $display("FAIL %s addr_%0d got=%h exp=%h", name, k, bus_if.bus_addr, {a[31:2], 2'b00}); end
      n_cmp++; if (bus_if.bus_wdata !== wd) begin n_err++; $display("FAIL %s wdata_%0d got=%h exp=%h", name, k, bus_if.bus_wdata, wd); end
      if (stall === 1'b1) stall_cnt++;
      if (bus_if.bus_req === 1'b1) req_cnt++;
      @(posedge clk); #1;
    end
    if (to) exp_terr = 1'b1;
    memread          = 1'b0;
    memwrite         = 1'b0;
    bus_if.bus_ready = 1'($urandom);
    bus_if.bus_rdata = $urandom;
    @(negedge clk);
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL %s done_stall got=%b exp=0", name, stall); end
    n_cmp++; if (bus_if.bus_req !== 1'b0) begin n_err++; $display("FAIL %s done_req got=%b exp=0", name, bus_if.bus_req); end
    n_cmp++; if (rdata !== exp_rdata) begin n_err++; $display("FAIL %s done_rdata got=%h exp=%h", name, rdata, exp_rdata); end
    n_cmp++; if (timeout_err !== exp_terr) begin n_err++; $display("FAIL %s timeout_err got=%b exp=%b", name, timeout_err, exp_terr); end
    n_cmp++; if (stall_cnt != req_cyc + 1) begin n_err++; $display("FAIL %s stall_cycles got=%0d exp=%0d", name, stall_cnt, req_cyc + 1); end
    n_cmp++; if (req_cnt != req_cyc) begin n_err++; $display("FAIL %s req_cycles got=%0d exp=%0d", name, req_cnt, req_cyc); end
    @(posedge clk); #1;
  endtask

  // Misaligned access: ignored by the bus, misalign pulses the following cycle only.
  task automatic run_misalign(input logic rd, input logic wr, input logic [31:0] a, input string name);
    memread  = rd;
    memwrite = wr;
    addr     = a;
    wdata    = $urandom;
    @(negedge clk);
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL %s stall got=%b exp=0", name, stall); end
    n_cmp++; if (bus_if.bus_req !== 1'b0) begin n_err++; $display("FAIL %s req0 got=%b exp=0", name, bus_if.bus_req); end
    @(posedge clk); #1;
    memread  = 1'b0;
    memwrite = 1'b0;
    @(negedge clk);
    n_cmp++; if (misalign !== 1'b1) begin n_err++; $display("FAIL %s pulse got=%b exp=1", name, misalign); end
    n_cmp++; if (bus_if.bus_req !== 1'b0) begin n_err++; $display("FAIL %s req1 got=%b exp=0", name, bus_if.bus_req); end
    n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL %s rdata got=%h exp=0", name, rdata); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL %s stall1 got=%b exp=0", name, stall); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (misalign !== 1'b0) begin n_err++; $display("FAIL %s pulse_end got=%b exp=0", name, misalign); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset            = 1'b0;
    memread          = 1'b1;
    addr             = 32'h40;
    bus_if.bus_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", stall); end
    n_cmp++; if (bus_if.bus_req !== 1'b0) begin n_err++; $display("FAIL reset_req got=%b exp=0", bus_if.bus_req); end
    n_cmp++; if (bus_if.bus_we !== 1'b0) begin n_err++; $display("FAIL reset_we got=%b exp=0", bus_if.bus_we); end
    n_cmp++; if (bus_if.bus_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr got=%h exp=0", bus_if.bus_addr); end
    n_cmp++; if (bus_if.bus_wdata !== 32'h0) begin n_err++; $display("FAIL reset_wdata got=%h exp=0", bus_if.bus_wdata); end
    n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    n_cmp++; if (misalign !== 1'b0) begin n_err++; $display("FAIL reset_misalign got=%b exp=0", misalign); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_terr got=%b exp=0", timeout_err); end
    memread          = 1'b0;
    bus_if.bus_ready = 1'b0;
    reset            = 1'b1;
    exp_terr         = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_read_immediate();
    run_access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 0, 32'h1234_5678, "read_imm");
  endtask

  task automatic test_write_waits();
    run_access(1'b0, 1'b1, 32'h0000_0100, 32'hCAFE_F00D, 3, 32'h5555_AAAA, "write_wait3");
  endtask

  task automatic test_misalign();
    run_misalign(1'b1, 1'b0, 32'h0000_0042, "misalign_load");
    run_misalign(1'b0, 1'b1, 32'h0000_0103, "misalign_store");
  endtask

  task automatic test_timeout();
    run_access(1'b1, 1'b0, 32'h0000_0200, 32'h0, TIMEOUT_P + 2, 32'h0, "timeout_read");
    run_access(1'b1, 1'b0, 32'h0000_0204, 32'h0, TIMEOUT_P - 1, 32'h0BAD_CAFE, "ready_at_limit");
    run_access(1'b0, 1'b1, 32'h0000_0208, 32'h1111_2222, 1, 32'h0, "after_timeout");
  endtask

  task automatic test_reset_mid();
    memread          = 1'b1;
    addr             = 32'h0000_0300;
    bus_if.bus_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_cmp++; if (bus_if.bus_req !== 1'b0) begin n_err++; $display("FAIL rst_mid_req got=%b exp=0", bus_if.bus_req); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_mid_stall got=%b exp=0", stall); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL rst_mid_terr got=%b exp=0", timeout_err); end
    n_cmp++; if (bus_if.bus_addr !== 32'h0) begin n_err++; $display("FAIL rst_mid_addr got=%h exp=0", bus_if.bus_addr); end
    exp_terr = 1'b0;
    memread  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus_if.bus_req !== 1'b0) begin n_err++; $display("FAIL rst_mid_idle_req got=%b exp=0", bus_if.bus_req); end
    run_access(1'b1, 1'b0, 32'h0000_0304, 32'h0, 2, 32'hFEED_0001, "after_reset");
  endtask

  task automatic test_back_to_back();
    run_access(1'b1, 1'b0, 32'h0000_0400, 32'h0, 0, 32'hA5A5_0001, "b2b_load");
    run_access(1'b0, 1'b1, 32'h0000_0404, 32'h5A5A_0002, 0, 32'h0, "b2b_store");
    run_access(1'b1, 1'b1, 32'h0000_0408, 32'h0F0F_0003, 1, 32'h7777_7777, "both_is_write");
  endtask

  task automatic test_random();
    for (int unsigned i = 0; i < 24; i++) begin
      logic [31:0] a  = $urandom;
      logic [1:0]  op = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) begin
        a[1:0] = 2'($urandom_range(1, 3));
        run_misalign(op[0], op[1], a, "rand_misalign");
      end else begin
        a[1:0] = 2'b00;
        run_access(op[0], op[1], a, $urandom, $urandom_range(0, 5), $urandom, "rand_access");
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before bench completed");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read_immediate();
    test_write_waits();
    test_misalign();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Sits between the single-cycle MIPS datapath's data-memory port (ALU result as address, register write data, memory read data back) and an external data bus with variable latency.
- Converts the datapath's zero-wait-state access into a req/ready handshake.
- Raises stall to freeze the PC and register writes until the access completes.
- Flags misaligned word accesses and bus timeouts.

Parameters:
- TIMEOUT, default 255: REQ cycles without bus_ready before the access is abandoned. Legal range 1..65535.
- ERR_DATA, default 32'hDEADBEEF: value returned on rdata for a timed-out read.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; block is in reset while reset==0.
- memread  input  1  datapath requests a word load this instruction.
- memwrite  input  1  datapath requests a word store this instruction.
- addr  input  32  byte address from the ALU.
- wdata  input  32  store data from the register file.
- rdata  output  32  load data to the result mux.
- stall  output  1  hold PC and suppress regwrite/memwrite commit while 1.
- misalign  output  1  one-cycle pulse: access ignored because addr[1:0]!=0.
- timeout_err  output  1  sticky; set on timeout, cleared only by reset.
- bus_req  output  1  registered; bus transfer request.
- bus_we  output  1  registered; 1=write, 0=read.
- bus_addr  output  32  registered word-aligned address.
- bus_wdata  output  32  registered write data.
- bus_ready  input  1  bus completes transfer in the cycle it is high with bus_req.
- bus_rdata  input  32  read data, valid with bus_ready on reads.

Behaviour:
- Reset (async, reset==0):
  - state=IDLE.
  - bus_req, bus_we, bus_addr, bus_wdata, rdata register, timeout counter, timeout_err and misalign all 0.
  - stall=0.
  - Reset mid-transfer drops bus_req immediately; no completion is reported.
- Access definition: access = memread|memwrite. Both high is treated as a write (bus_we=1); rdata is 0 in DONE for that access.
- IDLE:
  - access && addr[1:0]==0: stall=1 combinationally in the same cycle. At the edge, register bus_addr=addr, bus_wdata=wdata, bus_we=memwrite, bus_req=1, clear counter, go REQ.
  - access && addr[1:0]!=0: no bus activity, stall=0, rdata=0. The store is dropped. misalign is registered high for the following cycle. Stay IDLE.
  - No access: stall=0, rdata=0.
- REQ:
  - stall=1; bus_req, bus_we, bus_addr and bus_wdata are held stable.
  - bus_ready=1: capture bus_rdata into the rdata register (reads), drop bus_req at the edge, go DONE.
  - bus_ready=0: counter increments. When counter==TIMEOUT-1 and bus_ready is still 0: drop bus_req, set timeout_err, load rdata=ERR_DATA (reads) or 0 (writes), go DONE.
  - bus_ready and the timeout limit in the same cycle: ready wins; no error.
- DONE:
  - stall=0; rdata holds the captured value. The datapath commits at this edge.
  - Unconditional return to IDLE, so the same instruction is never re-issued.
  - rdata returns to 0 in IDLE.
- Latency: an aligned access with bus_ready in its first REQ cycle completes in 3 cycles (IDLE detect, REQ, DONE), stalling 2 of them. Each extra wait cycle adds 1.
- Input stability: addr, wdata, memread and memwrite are sampled only in IDLE. Changes during REQ/DONE are ignored.
- bus_ready outside REQ is ignored.

Test Plan:
- Read, immediate ready: memread=1, addr=0x0000_0040; bus_ready=1 and bus_rdata=0x1234_5678 in the first REQ cycle -> bus_req high 1 cycle with bus_we=0 and bus_addr=0x40; stall high 2 cycles; rdata=0x1234_5678 in DONE.
- Write, 3 wait states: memwrite=1, addr=0x100, wdata=0xCAFE_F00D; bus_ready on the 4th REQ cycle -> bus_we=1, bus_wdata=0xCAFE_F00D held 4 cycles; stall high 5 cycles; then DONE, then IDLE.
- Misaligned load: memread=1, addr=0x0000_0042 -> stall never asserts; bus_req stays 0; misalign pulses 1 cycle; rdata=0.
- Timeout with TIMEOUT=4: read, bus_ready held 0 -> bus_req drops after 4 REQ cycles; timeout_err=1 and stays 1; rdata=0xDEADBEEF in DONE; next access still works.
- Reset mid-transfer: drive reset=0 in the 2nd REQ cycle -> bus_req, stall and all outputs go 0 immediately (asynchronously); after release, state is IDLE and a new read completes normally.
- Back-to-back accesses: a load followed by a store on consecutive instructions -> exactly one bus transfer each, separated by the DONE→IDLE cycle; no duplicate request.
